// File: rtl/packet_former.sv
// Packet framer: emits SYNC, channel byte, PAY_LEN payload bytes pulled from
// the selected FIFO, then an 8-bit additive checksum, with valid/ready handshake.
module packet_former #(
    parameter int          PAY_LEN   = 30,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rdy_cnl,
    output logic       next,
    input  logic [7:0] f1_dout,
    input  logic [7:0] f2_dout,
    input  logic [7:0] f3_dout,
    output logic       f1_rd,
    output logic       f2_rd,
    output logic       f3_rd,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_sop,
    output logic       tx_eop
);

    localparam int CW = $clog2(PAY_LEN + 1);

    typedef enum logic [2:0] {WAIT, LATCH, SYNC, CHAN, RD, PAY, CSUM, DONE} state_t;

    state_t        state;
    logic          wait_cnt;
    logic [1:0]    code;
    logic [7:0]    csum;
    logic [CW-1:0] cnt;
    logic [7:0]    tx_reg;
    logic [7:0]    pay_byte;

    always_comb begin
        pay_byte = 8'h00;
        unique case (code)
            2'd1:    pay_byte = f1_dout;
            2'd2:    pay_byte = f2_dout;
            2'd3:    pay_byte = f3_dout;
            default: pay_byte = 8'h00;
        endcase
    end

    // FIFO data only arrives the cycle after the read strobe, so in PAY the
    // byte is presented straight from the FIFO, which holds it until the next read.
    always_comb begin
        tx_data = tx_reg;
        if (state == PAY)
            tx_data = pay_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT;
            wait_cnt <= 1'b0;
            code     <= '0;
            csum     <= '0;
            cnt      <= '0;
            tx_reg   <= '0;
            tx_valid <= 1'b0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
            next     <= 1'b0;
            f1_rd    <= 1'b0;
            f2_rd    <= 1'b0;
            f3_rd    <= 1'b0;
        end else begin
            unique case (state)
                WAIT: begin
                    if (wait_cnt) begin
                        wait_cnt <= 1'b0;
                        state    <= LATCH;
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end
                LATCH: begin
                    code     <= rdy_cnl;
                    csum     <= '0;
                    cnt      <= '0;
                    tx_reg   <= SYNC_BYTE;
                    tx_valid <= 1'b1;
                    tx_sop   <= 1'b1;
                    state    <= SYNC;
                end
                SYNC: begin
                    if (tx_ready) begin
                        tx_reg <= {6'b0, code};
                        tx_sop <= 1'b0;
                        state  <= CHAN;
                    end
                end
                CHAN: begin
                    if (tx_ready) begin
                        csum     <= {6'b0, code};
                        tx_valid <= 1'b0;
                        f1_rd    <= (code == 2'd1);
                        f2_rd    <= (code == 2'd2);
                        f3_rd    <= (code == 2'd3);
                        state    <= RD;
                    end
                end
                RD: begin
                    f1_rd    <= 1'b0;
                    f2_rd    <= 1'b0;
                    f3_rd    <= 1'b0;
                    tx_valid <= 1'b1;
                    state    <= PAY;
                end
                PAY: begin
                    if (tx_ready) begin
                        csum <= csum + pay_byte;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(PAY_LEN - 1)) begin
                            tx_reg <= csum + pay_byte;
                            tx_eop <= 1'b1;
                            state  <= CSUM;
                        end else begin
                            tx_valid <= 1'b0;
                            f1_rd    <= (code == 2'd1);
                            f2_rd    <= (code == 2'd2);
                            f3_rd    <= (code == 2'd3);
                            state    <= RD;
                        end
                    end
                end
                CSUM: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_eop   <= 1'b0;
                        next     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    next  <= 1'b0;
                    state <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_former.sv
// Self-checking bench for packet_former: FIFO/arbiter models feed the DUT and a
// scoreboard of expected bytes is checked at each accepted transfer.
module tb_packet_former;

    localparam int         PAY_LEN = 30;
    localparam logic [7:0] SYNC    = 8'hA5;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [1:0] code;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] rdy_cnl;
    logic       next;
    logic [7:0] f1_dout, f2_dout, f3_dout;
    logic       f1_rd, f2_rd, f3_rd;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_sop, tx_eop;

    int total = 0;
    int bad   = 0;

    exp_t       exp_q[$];
    logic [7:0] fq1[$], fq2[$], fq3[$];
    logic       stall_en = 1'b0;
    int         byte_idx = 0;

    packet_former #(.PAY_LEN(PAY_LEN), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .rdy_cnl(rdy_cnl), .next(next),
        .f1_dout(f1_dout), .f2_dout(f2_dout), .f3_dout(f3_dout),
        .f1_rd(f1_rd), .f2_rd(f2_rd), .f3_rd(f3_rd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_sop(tx_sop), .tx_eop(tx_eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO models: read data appears the cycle after the strobe and is held.
    initial begin
        f1_dout = 8'h00; f2_dout = 8'h00; f3_dout = 8'h00;
        forever begin
            @(posedge clk);
            if (f1_rd) f1_dout <= (fq1.size() > 0) ? fq1.pop_front() : 8'hxx;
            if (f2_rd) f2_dout <= (fq2.size() > 0) ? fq2.pop_front() : 8'hxx;
            if (f3_rd) f3_dout <= (fq3.size() > 0) ? fq3.pop_front() : 8'hxx;
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop, stall stability, next timing, rd pulses.
    initial begin
        exp_t e;
        logic prev_stall, eop_prev, prev_sop, prev_eop;
        logic [7:0] prev_data;
        int rdc1, rdc2, rdc3;
        prev_stall = 0; eop_prev = 0; prev_sop = 0; prev_eop = 0; prev_data = 0;
        rdc1 = 0; rdc2 = 0; rdc3 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0; eop_prev = 0; byte_idx = 0;
                rdc1 = 0; rdc2 = 0; rdc3 = 0;
            end else begin
                total++;
                assert (next === eop_prev) else begin
                    bad++; $error("FAIL next_pulse got=%b exp=%b", next, eop_prev);
                end
                if (f1_rd | f2_rd | f3_rd) begin
                    total++;
                    assert ($countones({f1_rd, f2_rd, f3_rd}) == 1) else begin
                        bad++; $error("FAIL rd_onehot got=%b exp=one-hot", {f1_rd, f2_rd, f3_rd});
                    end
                end
                rdc1 += int'(f1_rd); rdc2 += int'(f2_rd); rdc3 += int'(f3_rd);
                if (prev_stall) begin
                    total++;
                    assert ({tx_valid, tx_data, tx_sop, tx_eop} === {1'b1, prev_data, prev_sop, prev_eop}) else begin
                        bad++; $error("FAIL stall_hold got=%h exp=%h", {tx_valid, tx_data, tx_sop, tx_eop},
                                      {1'b1, prev_data, prev_sop, prev_eop});
                    end
                end
                eop_prev = 1'b0;
                if (tx_valid && tx_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++; $error("FAIL extra_byte got=%h exp=none", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        assert ({tx_data, tx_sop, tx_eop} === {e.data, e.sop, e.eop}) else begin
                            bad++; $error("FAIL byte%0d got=%h/%b/%b exp=%h/%b/%b", byte_idx + 1,
                                          tx_data, tx_sop, tx_eop, e.data, e.sop, e.eop);
                        end
                        if (e.sop) begin
                            byte_idx = 1; rdc1 = 0; rdc2 = 0; rdc3 = 0;
                        end else begin
                            byte_idx++;
                        end
                        if (e.eop) begin
                            total++;
                            assert ({rdc1, rdc2, rdc3} === {(e.code == 2'd1) ? PAY_LEN : 0,
                                                            (e.code == 2'd2) ? PAY_LEN : 0,
                                                            (e.code == 2'd3) ? PAY_LEN : 0}) else begin
                                bad++; $error("FAIL rd_count code=%0d got=%0d/%0d/%0d", e.code, rdc1, rdc2, rdc3);
                            end
                        end
                    end
                    eop_prev = tx_eop;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data; prev_sop = tx_sop; prev_eop = tx_eop;
            end
        end
    end

    // pattern 0: ascending 1..PAY_LEN, 1: all FF, other: random
    task automatic push_pkt(input logic [1:0] code, input int pattern);
        logic [7:0] b, sum;
        exp_q.push_back('{data: SYNC, sop: 1'b1, eop: 1'b0, code: code});
        exp_q.push_back('{data: {6'b0, code}, sop: 1'b0, eop: 1'b0, code: code});
        sum = {6'b0, code};
        for (int i = 0; i < PAY_LEN; i++) begin
            case (pattern)
                0:       b = 8'(i + 1);
                1:       b = 8'hFF;
                default: b = 8'($urandom_range(0, 255));
            endcase
            if (code == 2'd0) b = 8'h00;
            case (code)
                2'd1: fq1.push_back(b);
                2'd2: fq2.push_back(b);
                2'd3: fq3.push_back(b);
                default: ;
            endcase
            sum = sum + b;
            exp_q.push_back('{data: b, sop: 1'b0, eop: 1'b0, code: code});
        end
        exp_q.push_back('{data: sum, sop: 1'b0, eop: 1'b1, code: code});
    endtask

    // Called at the negedge where next is seen: rdy_cnl is wrong for one cycle,
    // correct through the latch edge, then wrong again for the rest of the packet.
    task automatic start_pkt(input logic [1:0] code, input int pattern);
        rdy_cnl = ~code;
        push_pkt(code, pattern);
        @(posedge clk); #1;
        rdy_cnl = code;
        repeat (3) @(posedge clk);
        #1;
        rdy_cnl = ~code;
    endtask

    task automatic wait_next(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (next !== 1'b1 && n < budget);
        total++;
        assert (next === 1'b1) else begin
            bad++; $error("FAIL wait_next got=%b exp=1 after %0d cycles", next, n);
        end
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        rdy_cnl = 2'd1;
        push_pkt(2'd1, 0);
        repeat (3) @(negedge clk);
        total++;
        assert ({tx_valid, tx_sop, tx_eop, next, f1_rd, f2_rd, f3_rd, tx_data} === 15'h0) else begin
            bad++; $error("FAIL reset_out got=%h exp=0", {tx_valid, tx_sop, tx_eop, next, f1_rd, f2_rd, f3_rd, tx_data});
        end
        rst_n = 1'b1;
        wait_next(200);

        start_pkt(2'd0, 0);
        wait_next(200);
        start_pkt(2'd2, 1);
        wait_next(200);

        stall_en = 1'b1;
        start_pkt(2'd3, 2);
        wait_next(2000);
        stall_en = 1'b0;

        start_pkt(2'd1, 2); wait_next(200);
        start_pkt(2'd2, 2); wait_next(200);
        start_pkt(2'd3, 0); wait_next(200);
        start_pkt(2'd0, 0); wait_next(200);

        // abandon a packet while payload byte 10 is on the bus
        start_pkt(2'd1, 0);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(byte_idx == 12 && tx_valid) && n < 500);
        total++;
        assert (byte_idx == 12) else begin
            bad++; $error("FAIL reach_byte10 got=%0d exp=12", byte_idx);
        end
        rst_n = 1'b0;
        #1;
        total++;
        assert ({tx_valid, tx_sop, tx_eop, next, f1_rd, f2_rd, f3_rd, tx_data} === 15'h0) else begin
            bad++; $error("FAIL midreset_out got=%h exp=0", {tx_valid, tx_sop, tx_eop, next, f1_rd, f2_rd, f3_rd, tx_data});
        end
        exp_q.delete();
        fq1.delete();
        rdy_cnl = 2'd3;
        push_pkt(2'd3, 2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_next(200);
        @(negedge clk);
        total++;
        assert (exp_q.size() == 0) else begin
            bad++; $error("FAIL leftover got=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_former.md
PACKET_FORMER -- requirements
Module: packet_former

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PAY_LEN, 30, payload bytes per packet.
- SYNC_BYTE, 8'hA5, first byte of every packet.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- rdy_cnl, in, 2, arbiter channel code (0 = empty packet, 1..3 = FIFO index).
- next, out, 1, one-cycle pulse requesting the next arbitration.
- f1_dout / f2_dout / f3_dout, in, 8 each, FIFO read data; valid the cycle after the matching rd.
- f1_rd / f2_rd / f3_rd, out, 1 each, FIFO read strobes, one cycle per byte.
- tx_data, out, 8, packet byte.
- tx_valid, out, 1, tx_data valid.
- tx_ready, in, 1, sink accepts the byte when tx_valid && tx_ready at a rising edge.
- tx_sop / tx_eop, out, 1 each, asserted with the first / last byte of a packet.

Function
REQ-003 Packet format, in order: SYNC_BYTE, channel byte {6'b0, code}, PAY_LEN payload bytes, checksum; total PAY_LEN+3 = 33 bytes.
REQ-004 Checksum = 8-bit sum, modulo 256, of the channel byte and all payload bytes; SYNC_BYTE is excluded; carries are discarded.
REQ-005 Code 0 (empty packet): payload is PAY_LEN bytes of 8'h00; no fN_rd is asserted.
REQ-006 States: WAIT, LATCH, SYNC, CHAN, RD, PAY, CSUM, DONE.
REQ-007 WAIT counts 2 cycles, then goes to LATCH; entered after reset release and after every next pulse (the arbiter's code is stable 2 cycles after next).
REQ-008 LATCH registers rdy_cnl into an internal code register, clears the checksum and byte counter, then goes to SYNC; rdy_cnl is ignored in every other state.
REQ-009 SYNC / CHAN / PAY / CSUM each hold tx_data with tx_valid=1 until tx_ready is sampled high, then advance; tx_data is held stable while stalled.
REQ-010 RD lasts exactly 1 cycle: it pulses the fN_rd selected by the latched code (none for code 0); the next cycle, PAY captures fN_dout (or 8'h00) into tx_data.
REQ-011 PAY accepted: add the byte to the checksum and increment the counter; if count < PAY_LEN go to RD, else go to CSUM.
REQ-012 tx_sop is high only in SYNC; tx_eop is high only in CSUM.
REQ-013 CSUM accepted goes to DONE; DONE asserts next for exactly 1 cycle, then goes to WAIT.
REQ-014 At most one fN_rd is high in any cycle; exactly PAY_LEN rd pulses per non-empty packet.
REQ-015 tx_valid is 0 in WAIT, LATCH, RD and DONE.
REQ-016 tx_ready high outside a valid state has no effect.
REQ-017 The block does not check FIFO occupancy; the arbiter guarantees ≥ PAY_LEN bytes before issuing a non-zero code.

Reset
REQ-018 rst_n low, asynchronously: state=WAIT with count 0, and tx_data=8'h00, tx_valid=0, tx_sop=0, tx_eop=0, next=0, all fN_rd=0, code/checksum/counter=0.
REQ-019 Reset asserted mid-packet abandons the packet with no eop; after release, the block restarts the 2-cycle WAIT and no next pulse is issued for the abandoned packet.

Verification
REQ-020 Code 1, FIFO1 bytes 8'h01..8'h1E, tx_ready tied 1 -> A5, 01, 01..1E, D2; sop on A5, eop on D2; 30 f1_rd pulses; next 1 cycle after eop accepted.
REQ-021 Code 0 -> A5, 00, thirty 00, 00; no fN_rd ever high; then one next pulse.
REQ-022 Code 2, FIFO2 all 8'hFF -> checksum E4 (carry wraparound); only f2_rd toggles.
REQ-023 Random tx_ready stalls on code 3 -> tx_data stable while stalled, no byte lost or duplicated, exactly 30 f3_rd pulses, 33 accepted bytes.
REQ-024 rst_n pulsed low during payload byte 10 -> outputs zero immediately, no eop; first packet after release starts with A5 and sop, using the code sampled 2 cycles after release.
REQ-025 Back-to-back codes 1, 2, 3, 0 from an arbiter model -> four well-formed packets in that order; rdy_cnl sampled exactly 2 cycles after each next pulse.
